config_register_bank: RTL and testbench
=======================================

Name: config_register_bank

Overview:
Parametrised configuration/status register bank, successor to the fixed 16x8 register file feeding the UART/ALU system controller.
- Per-register reset values and a per-register read-only mask.
- Configurable read latency (1 or 2 cycles), access-error reporting, and per-register write-update strobes.
- A hardware status write port so datapath blocks can post results.
- Sits between the system controller (bus side) and the UART/ALU/clock-divider config inputs (export side).

Parameters:
DATA_WIDTH, 8, width of each register
DEPTH, 16, number of registers (need not be a power of two)
ADDR_WIDTH, $clog2(DEPTH), address width (derived, not overridden)
EXPORT_COUNT, 4, registers 0..EXPORT_COUNT-1 driven continuously on export_bus (1..DEPTH)
RESET_VALUES, 128'h0000_0000_0000_0000_0000_0000_2001_0000, flattened DEPTH*DATA_WIDTH reset image; register i = bits [i*DATA_WIDTH +: DATA_WIDTH] (default: reg2=0x01 parity enable, reg3=0x20 prescale 32)
READ_ONLY_MASK, 16'h0000, bit i=1 makes register i read-only from the bus side
READ_LATENCY, 1, 1 or 2 cycles from read request to read_data_valid

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
address  input  ADDR_WIDTH  bus-side register index
write_enable  input  1  bus write request, single-cycle qualified
write_data  input  DATA_WIDTH  bus write data
read_enable  input  1  bus read request, single-cycle qualified
read_data  output  DATA_WIDTH  read result, held until next valid read
read_data_valid  output  1  one-cycle pulse with read_data
access_error  output  1  one-cycle pulse for a rejected bus access
hw_write_enable  input  1  hardware status write strobe
hw_write_address  input  ADDR_WIDTH  hardware write index
hw_write_data  input  DATA_WIDTH  hardware write data
export_bus  output  EXPORT_COUNT*DATA_WIDTH  registers 0..EXPORT_COUNT-1, register i at [i*DATA_WIDTH +: DATA_WIDTH]
register_updated  output  EXPORT_COUNT  one-cycle pulse per exported register whose value was written (bus or hw)

Behaviour:
- Reset (reset low, async): every register loads its RESET_VALUES slice.
- Reset also clears read_data, read_data_valid, access_error, register_updated and the read pipeline to 0. A read in flight during reset is dropped and never returns.
- Bus write (write_enable=1, read_enable=0, address<DEPTH, READ_ONLY_MASK[address]=0): register updates at the clock edge. No read_data_valid.
- Bus read (read_enable=1, write_enable=0, address<DEPTH):
  - Register sampled at the request edge.
  - READ_LATENCY=1: read_data/read_data_valid appear at that edge.
  - READ_LATENCY=2: one extra pipeline stage. Back-to-back reads are allowed every cycle, one result per cycle, in order.
- Read-only registers are readable. Reads never alter state.
- The following are errors. Each causes no state change and access_error pulses 1 cycle after the request edge:
  - write_enable and read_enable both asserted;
  - address >= DEPTH on either request;
  - bus write to a read-only register.
- Erroneous reads produce no read_data_valid; read_data holds its prior value.
- Hardware write:
  - hw_write_enable with hw_write_address<DEPTH writes regardless of READ_ONLY_MASK.
  - Out-of-range hardware address is ignored silently (no error).
  - Same edge, same address as a valid bus write: the bus write wins and the hw write is discarded.
  - Different addresses: both take effect.
- Read/write same cycle, different sources: a read sampling a register being hw-written the same edge returns the OLD value.
- register_updated[i] pulses 1 cycle after any accepted write to register i (i<EXPORT_COUNT), even if the data is unchanged. Multiple bits may pulse together.
- export_bus is a direct combinational view of the register storage; it reflects writes immediately after the write edge.
- read_data_valid and access_error are never asserted in the same cycle for the same request.

Test Plan:
- Reset with defaults -> export_bus = 0x20_01_00_00, read reg2 returns 0x01 with read_data_valid 1 cycle later, access_error 0.
- Bus write 0xA5 to reg1, then read reg1 -> register_updated = 4'b0010 for 1 cycle, export_bus[15:8]=0xA5, read_data=0xA5.
- DEPTH=12, READ_ONLY_MASK=12'h010: bus write reg4 and read address 13 -> two access_error pulses, reg4 keeps its reset value, no read_data_valid. hw write 0x3C to reg4 -> read returns 0x3C.
- Simultaneous bus write 0x11 and hw write 0x22 to reg0 -> reg0=0x11, register_updated[0] pulses once. write_enable+read_enable together -> access_error, no change.
- READ_LATENCY=2, reads of reg0..reg3 on four consecutive cycles -> four consecutive valid pulses starting 2 cycles after the first request, data in order.
- Assert reset one cycle after a READ_LATENCY=2 read -> no read_data_valid ever appears, all registers return to RESET_VALUES.

Source files
------------

// File: rtl/config_register_bank.sv
// Configuration/status register bank: bus read/write port with access checking,
// hardware status write port, exported register view and per-register update strobes.
module config_register_bank #(
  parameter int                            DATA_WIDTH     = 8,
  parameter int                            DEPTH          = 16,
  parameter int                            ADDR_WIDTH     = $clog2(DEPTH),
  parameter int                            EXPORT_COUNT   = 4,
  parameter logic [DEPTH*DATA_WIDTH-1:0]   RESET_VALUES   = 128'h0000_0000_0000_0000_0000_0000_2001_0000,
  parameter logic [DEPTH-1:0]              READ_ONLY_MASK = '0,
  parameter int                            READ_LATENCY   = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [ADDR_WIDTH-1:0]              address,
  input  logic                               write_enable,
  input  logic [DATA_WIDTH-1:0]              write_data,
  input  logic                               read_enable,
  output logic [DATA_WIDTH-1:0]              read_data,
  output logic                               read_data_valid,
  output logic                               access_error,
  input  logic                               hw_write_enable,
  input  logic [ADDR_WIDTH-1:0]              hw_write_address,
  input  logic [DATA_WIDTH-1:0]              hw_write_data,
  output logic [EXPORT_COUNT*DATA_WIDTH-1:0] export_bus,
  output logic [EXPORT_COUNT-1:0]            register_updated
);

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0]   regs_q [DEPTH];
  logic [DATA_WIDTH-1:0]   regs_d [DEPTH];
  logic [EXPORT_COUNT-1:0] upd_q, upd_d;
  logic                    err_q;
  logic                    rd_vld_p1_q;
  logic [DATA_WIDTH-1:0]   rd_data_p1_q;

  logic bus_in_range, hw_in_range, bus_wr_ok, bus_rd_ok, req_err, hw_wr_ok;

  assign bus_in_range = {1'b0, address} < DEPTH_W;
  assign hw_in_range  = {1'b0, hw_write_address} < DEPTH_W;
  assign bus_wr_ok    = write_enable && !read_enable && bus_in_range && !READ_ONLY_MASK[address];
  assign bus_rd_ok    = read_enable && !write_enable && bus_in_range;
  assign req_err      = (write_enable || read_enable) && !bus_wr_ok && !bus_rd_ok;
  assign hw_wr_ok     = hw_write_enable && hw_in_range;

  // Bus write takes priority over a hardware write to the same register.
  always_comb begin
    regs_d = regs_q;
    upd_d  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus_wr_ok && address == ADDR_WIDTH'(i))
        regs_d[i] = write_data;
      else if (hw_wr_ok && hw_write_address == ADDR_WIDTH'(i))
        regs_d[i] = hw_write_data;
    end
    for (int i = 0; i < EXPORT_COUNT; i++) begin
      upd_d[i] = (bus_wr_ok && address == ADDR_WIDTH'(i)) ||
                 (hw_wr_ok && hw_write_address == ADDR_WIDTH'(i));
    end
  end

  // Stage p1: storage update and read sample of the pre-write contents
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++)
        regs_q[i] <= RESET_VALUES[i*DATA_WIDTH +: DATA_WIDTH];
      upd_q        <= '0;
      err_q        <= 1'b0;
      rd_vld_p1_q  <= 1'b0;
      rd_data_p1_q <= '0;
    end else begin
      regs_q      <= regs_d;
      upd_q       <= upd_d;
      err_q       <= req_err;
      rd_vld_p1_q <= bus_rd_ok;
      if (bus_rd_ok)
        rd_data_p1_q <= regs_q[address];
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  rd_vld_p2_q;
      logic [DATA_WIDTH-1:0] rd_data_p2_q;

      // Stage p2: extra output register, data held between valid reads
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          rd_vld_p2_q  <= 1'b0;
          rd_data_p2_q <= '0;
        end else begin
          rd_vld_p2_q <= rd_vld_p1_q;
          if (rd_vld_p1_q)
            rd_data_p2_q <= rd_data_p1_q;
        end
      end

      assign read_data       = rd_data_p2_q;
      assign read_data_valid = rd_vld_p2_q;
    end else begin : g_lat1
      assign read_data       = rd_data_p1_q;
      assign read_data_valid = rd_vld_p1_q;
    end
  endgenerate

  for (genvar g = 0; g < EXPORT_COUNT; g++) begin : g_export
    assign export_bus[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

  assign access_error     = err_q;
  assign register_updated = upd_q;

endmodule

// File: tb/tb_config_register_bank.sv
// Directed bench: instance A uses defaults (16 regs, latency 1); instance B has
// 12 regs, reg4 read-only with reset value 0x44, latency 2. Both share stimulus.
module tb_config_register_bank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] address = '0;
  logic       we = 1'b0, re = 1'b0, hwe = 1'b0;
  logic [7:0] wd = '0, hwd = '0;
  logic [3:0] hwa = '0;

  logic [7:0]  rd_a, rd_b;
  logic        vld_a, vld_b, err_a, err_b;
  logic [31:0] exp_a, exp_b;
  logic [3:0]  upd_a, upd_b;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] seq [4];

  always #5 clk = ~clk;

  config_register_bank dut_a (
    .clk(clk), .reset(rst_n), .address(address), .write_enable(we), .write_data(wd),
    .read_enable(re), .read_data(rd_a), .read_data_valid(vld_a), .access_error(err_a),
    .hw_write_enable(hwe), .hw_write_address(hwa), .hw_write_data(hwd),
    .export_bus(exp_a), .register_updated(upd_a)
  );

  config_register_bank #(
    .DEPTH(12),
    .RESET_VALUES(96'h0000_0000_0000_0044_2001_0000),
    .READ_ONLY_MASK(12'h010),
    .READ_LATENCY(2)
  ) dut_b (
    .clk(clk), .reset(rst_n), .address(address), .write_enable(we), .write_data(wd),
    .read_enable(re), .read_data(rd_b), .read_data_valid(vld_b), .access_error(err_b),
    .hw_write_enable(hwe), .hw_write_address(hwa), .hw_write_data(hwd),
    .export_bus(exp_b), .register_updated(upd_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  initial begin
    #2 rst_n = 1'b0;
    tick();
    chk("rst_export_a", exp_a, 32'h2001_0000);
    chk("rst_export_b", exp_b, 32'h2001_0000);
    chk("rst_rdata_a", {24'h0, rd_a}, 32'h0);
    chk("rst_vld_a", {31'h0, vld_a}, 32'h0);
    chk("rst_err_a", {31'h0, err_a}, 32'h0);
    chk("rst_upd_a", {28'h0, upd_a}, 32'h0);
    chk("rst_vld_b", {31'h0, vld_b}, 32'h0);
    rst_n = 1'b1;

    // read reg2 after reset
    address = 4'd2; re = 1'b1;
    tick();
    chk("rd2_vld_a", {31'h0, vld_a}, 32'h1);
    chk("rd2_data_a", {24'h0, rd_a}, 32'h01);
    chk("rd2_err_a", {31'h0, err_a}, 32'h0);
    chk("rd2_vld_b_early", {31'h0, vld_b}, 32'h0);
    re = 1'b0;
    tick();
    chk("rd2_vld_b", {31'h0, vld_b}, 32'h1);
    chk("rd2_data_b", {24'h0, rd_b}, 32'h01);
    chk("rd2_vld_a_drop", {31'h0, vld_a}, 32'h0);
    chk("rd2_hold_a", {24'h0, rd_a}, 32'h01);

    // bus write 0xA5 to reg1
    address = 4'd1; we = 1'b1; wd = 8'hA5;
    tick();
    chk("wr1_upd_a", {28'h0, upd_a}, 32'h2);
    chk("wr1_upd_b", {28'h0, upd_b}, 32'h2);
    chk("wr1_export_a", {24'h0, exp_a[15:8]}, 32'hA5);
    chk("wr1_vld_a", {31'h0, vld_a}, 32'h0);
    chk("wr1_err_a", {31'h0, err_a}, 32'h0);
    we = 1'b0;
    tick();
    chk("wr1_upd_pulse_a", {28'h0, upd_a}, 32'h0);
    re = 1'b1;
    tick();
    chk("rd1_data_a", {24'h0, rd_a}, 32'hA5);
    chk("rd1_vld_a", {31'h0, vld_a}, 32'h1);
    re = 1'b0;
    tick();
    chk("rd1_data_b", {24'h0, rd_b}, 32'hA5);

    // write to reg4: read-only only in B
    address = 4'd4; we = 1'b1; wd = 8'h99;
    tick();
    chk("ro_err_b", {31'h0, err_b}, 32'h1);
    chk("ro_err_a", {31'h0, err_a}, 32'h0);
    chk("ro_upd_b", {28'h0, upd_b}, 32'h0);
    we = 1'b0;
    tick();
    chk("ro_err_pulse_b", {31'h0, err_b}, 32'h0);
    // address 13: out of range for B only
    address = 4'd13; re = 1'b1;
    tick();
    chk("oor_err_b", {31'h0, err_b}, 32'h1);
    chk("oor_err_a", {31'h0, err_a}, 32'h0);
    chk("oor_vld_a", {31'h0, vld_a}, 32'h1);
    chk("oor_data_a", {24'h0, rd_a}, 32'h00);
    re = 1'b0;
    tick();
    chk("oor_err_pulse_b", {31'h0, err_b}, 32'h0);
    chk("oor_vld_b", {31'h0, vld_b}, 32'h0);
    chk("oor_hold_b", {24'h0, rd_b}, 32'hA5);
    address = 4'd4; re = 1'b1;
    tick();
    chk("rd4_data_a", {24'h0, rd_a}, 32'h99);
    re = 1'b0;
    tick();
    chk("rd4_data_b", {24'h0, rd_b}, 32'h44);
    chk("rd4_vld_b", {31'h0, vld_b}, 32'h1);

    // hardware write bypasses read-only
    hwe = 1'b1; hwa = 4'd4; hwd = 8'h3C;
    tick();
    chk("hw4_err_b", {31'h0, err_b}, 32'h0);
    hwe = 1'b0; re = 1'b1;
    tick();
    chk("hw4_data_a", {24'h0, rd_a}, 32'h3C);
    re = 1'b0;
    tick();
    chk("hw4_data_b", {24'h0, rd_b}, 32'h3C);

    // bus and hw write collide on reg0
    address = 4'd0; we = 1'b1; wd = 8'h11; hwe = 1'b1; hwa = 4'd0; hwd = 8'h22;
    tick();
    chk("col_export_a", {24'h0, exp_a[7:0]}, 32'h11);
    chk("col_export_b", {24'h0, exp_b[7:0]}, 32'h11);
    chk("col_upd_a", {28'h0, upd_a}, 32'h1);
    chk("col_upd_b", {28'h0, upd_b}, 32'h1);
    we = 1'b0; hwe = 1'b0;
    tick();
    chk("col_upd_pulse_a", {28'h0, upd_a}, 32'h0);

    // bus and hw writes to different registers
    address = 4'd1; we = 1'b1; wd = 8'h55; hwe = 1'b1; hwa = 4'd3; hwd = 8'h66;
    tick();
    chk("dual_upd_a", {28'h0, upd_a}, 32'hA);
    chk("dual_export_a", exp_a, 32'h6601_5511);
    chk("dual_export_b", exp_b, 32'h6601_5511);

    // read reg3 while hw overwrites it: old value returned
    we = 1'b0; re = 1'b1; address = 4'd3; hwe = 1'b1; hwa = 4'd3; hwd = 8'h77;
    tick();
    chk("rdw_data_a", {24'h0, rd_a}, 32'h66);
    chk("rdw_export_a", {24'h0, exp_a[31:24]}, 32'h77);
    chk("rdw_upd_a", {28'h0, upd_a}, 32'h8);
    re = 1'b0; hwe = 1'b0;
    tick();
    chk("rdw_data_b", {24'h0, rd_b}, 32'h66);

    // write and read together
    address = 4'd0; we = 1'b1; re = 1'b1; wd = 8'hFF;
    tick();
    chk("wr_rd_err_a", {31'h0, err_a}, 32'h1);
    chk("wr_rd_err_b", {31'h0, err_b}, 32'h1);
    chk("wr_rd_vld_a", {31'h0, vld_a}, 32'h0);
    chk("wr_rd_export_a", exp_a, 32'h7701_5511);
    chk("wr_rd_upd_a", {28'h0, upd_a}, 32'h0);
    we = 1'b0; re = 1'b0;
    tick();
    chk("wr_rd_vld_b", {31'h0, vld_b}, 32'h0);
    chk("wr_rd_err_pulse_a", {31'h0, err_a}, 32'h0);

    // back-to-back reads of reg0..reg3
    seq[0] = 8'h11; seq[1] = 8'h55; seq[2] = 8'h01; seq[3] = 8'h77;
    for (int i = 0; i < 4; i++) begin
      address = 4'(i); re = 1'b1;
      tick();
      chk($sformatf("b2b_data_a%0d", i), {24'h0, rd_a}, {24'h0, seq[i]});
      chk($sformatf("b2b_vld_a%0d", i), {31'h0, vld_a}, 32'h1);
      if (i == 0) begin
        chk("b2b_vld_b_first", {31'h0, vld_b}, 32'h0);
      end else begin
        chk($sformatf("b2b_vld_b%0d", i - 1), {31'h0, vld_b}, 32'h1);
        chk($sformatf("b2b_data_b%0d", i - 1), {24'h0, rd_b}, {24'h0, seq[i-1]});
      end
    end
    re = 1'b0;
    tick();
    chk("b2b_vld_b3", {31'h0, vld_b}, 32'h1);
    chk("b2b_data_b3", {24'h0, rd_b}, 32'h77);
    chk("b2b_vld_a_end", {31'h0, vld_a}, 32'h0);
    tick();
    chk("b2b_vld_b_end", {31'h0, vld_b}, 32'h0);

    // reset while a latency-2 read is in flight
    address = 4'd2; re = 1'b1;
    tick();
    re = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld_b", {31'h0, vld_b}, 32'h0);
    chk("mid_rst_data_b", {24'h0, rd_b}, 32'h0);
    chk("mid_rst_data_a", {24'h0, rd_a}, 32'h0);
    chk("mid_rst_export_a", exp_a, 32'h2001_0000);
    chk("mid_rst_export_b", exp_b, 32'h2001_0000);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_vld_b1", {31'h0, vld_b}, 32'h0);
    tick();
    chk("post_rst_vld_b2", {31'h0, vld_b}, 32'h0);
    address = 4'd4; re = 1'b1;
    tick();
    chk("post_rst_rd4_a", {24'h0, rd_a}, 32'h00);
    re = 1'b0;
    tick();
    chk("post_rst_rd4_b", {24'h0, rd_b}, 32'h44);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
